// File: rtl/pingpong_frame_buffer.sv
// Double-banked frame store: a streaming writer fills the back bank while a random-access
// reader sees the front bank; banks swap once the back frame is complete and unlocked.
module pingpong_frame_buffer #(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned DEPTH      = 4800,
  parameter int unsigned ADDR_W     = 14,
  parameter string       INIT_FILE0 = "",
  parameter string       INIT_FILE1 = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic              wr_sof,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] wr_count,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_lock,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              front_bank,
  output logic              swapped
);

  localparam int unsigned       MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // Preload images only make sense for a simulation model; this build leaves banks undefined.
  if (INIT_FILE0 != "" || INIT_FILE1 != "") begin : g_preload_ignored
  end

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_count_nxt;
  logic              wr_ready_nxt;
  logic              front_bank_nxt;
  logic              swapped_nxt;
  logic              wr_en_c;
  logic [MEM_AW-1:0] wr_addr_c;
  logic              rd_oob_c;
  logic [MEM_AW-1:0] rd_idx_c;
  logic [DATA_W-1:0] rd_word_c;

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      wr_count   <= '0;
      wr_ready   <= 1'b0;
      front_bank <= 1'b0;
      swapped    <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_count   <= wr_count_nxt;
      wr_ready   <= wr_ready_nxt;
      front_bank <= front_bank_nxt;
      swapped    <= swapped_nxt;
    end
  end

  // Fill/swap sequencing and write-port control
  always_comb begin
    state_nxt      = state;
    wr_count_nxt   = wr_count;
    wr_ready_nxt   = wr_ready;
    front_bank_nxt = front_bank;
    swapped_nxt    = 1'b0;
    wr_en_c        = 1'b0;
    wr_addr_c      = MEM_AW'(wr_count);
    case (state)
      FILL: begin
        wr_ready_nxt = 1'b1;
        if (wr_valid && wr_ready) begin
          wr_en_c = 1'b1;
          if (wr_sof) begin
            wr_addr_c    = '0;
            wr_count_nxt = ADDR_W'(1);
          end else if (wr_count == LAST_ADDR) begin
            // Count parks at the last address until the swap clears it.
            state_nxt    = FULL;
            wr_ready_nxt = 1'b0;
          end else begin
            wr_count_nxt = wr_count + ADDR_W'(1);
          end
        end
      end
      FULL: begin
        wr_ready_nxt = 1'b0;
        if (!rd_lock) begin
          front_bank_nxt = ~front_bank;
          swapped_nxt    = 1'b1;
          wr_count_nxt   = '0;
          state_nxt      = FILL;
          wr_ready_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // Back-bank write port; the bank written is always the one the reader is not using
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      if (front_bank) begin
        bank0[wr_addr_c] <= wr_data;
      end else begin
        bank1[wr_addr_c] <= wr_data;
      end
    end
  end

  assign rd_oob_c  = {1'b0, rd_addr} >= DEPTH_EXT;
  assign rd_idx_c  = rd_oob_c ? '0 : MEM_AW'(rd_addr);
  assign rd_word_c = front_bank ? bank1[rd_idx_c] : bank0[rd_idx_c];

  // Front-bank read port with registered output; data holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && rd_oob_c;
      if (rd_en) begin
        rd_data <= rd_oob_c ? '0 : rd_word_c;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Bench for pingpong_frame_buffer: frame streaming, bank swap, lock hold-off,
// sof restart, out-of-range reads and mid-frame reset, with a read scoreboard.
module tb_pingpong_frame_buffer;

  localparam int unsigned DATA_W = 9;
  localparam int unsigned DEPTH  = 4800;
  localparam int unsigned ADDR_W = 14;

  logic              clk;
  logic              rst_n;
  logic              wr_valid;
  logic              wr_sof;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_lock;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic              front_bank;
  logic              swapped;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_data;
    logic              exp_err;
  } rd_vec_t;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t           exp_q[$];
  logic [DATA_W-1:0] ref_mem [2][DEPTH];
  logic              ref_front;
  int                ref_wr_addr;
  int                n_checks = 0;
  int                n_pass   = 0;

  pingpong_frame_buffer #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE0(""),
    .INIT_FILE1("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_sof    (wr_sof),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .wr_count  (wr_count),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_lock   (rd_lock),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err),
    .front_bank(front_bank),
    .swapped   (swapped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] pat(input int s, input int i);
    return DATA_W'(i * (2 * s + 1) + s * 37);
  endfunction

  // One pixel, waiting (bounded) for wr_ready; the model records where it lands.
  task automatic write_px(input logic sof, input logic [DATA_W-1:0] d);
    int guard;
    int a;
    guard = 0;
    while (wr_ready !== 1'b1 && guard < 64) begin
      tick();
      guard++;
    end
    if (wr_ready !== 1'b1) begin
      chk("wr_ready_wait", 32'(wr_ready), 32'd1);
      return;
    end
    wr_valid = 1'b1;
    wr_sof   = sof;
    wr_data  = d;
    a = sof ? 0 : ref_wr_addr;
    tick();
    ref_mem[~ref_front][a] = d;
    ref_wr_addr = a + 1;
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  task automatic issue_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] ed,
                            input logic ee);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back(rd_exp_t'{err: ee, data: ed});
    tick();
    rd_en = 1'b0;
  endtask

  // Read scoreboard: every rd_valid pulse consumes exactly one expectation.
  always @(negedge clk) begin
    rd_exp_t e;
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.data));
        chk("rd_err", 32'(rd_err), 32'(e.err));
      end
    end else if (rst_n && rd_err) begin
      chk("rd_err_without_valid", 32'(rd_err), 32'd0);
    end
  end

  initial begin
    rd_vec_t tbl [6];
    int      ra;
    tbl[0] = '{addr: 14'd0,     exp_data: 9'h000, exp_err: 1'b0};
    tbl[1] = '{addr: 14'd255,   exp_data: 9'h0FF, exp_err: 1'b0};
    tbl[2] = '{addr: 14'd4799,  exp_data: 9'h0BF, exp_err: 1'b0};
    tbl[3] = '{addr: 14'd4800,  exp_data: 9'h000, exp_err: 1'b1};
    tbl[4] = '{addr: 14'd16383, exp_data: 9'h000, exp_err: 1'b1};
    tbl[5] = '{addr: 14'd1,     exp_data: 9'h001, exp_err: 1'b0};

    rst_n = 1'b0; wr_valid = 1'b0; wr_sof = 1'b0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_lock = 1'b0;
    ref_front = 1'b0; ref_wr_addr = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_count",   32'(wr_count),   32'd0);
    chk("rst_wr_ready",   32'(wr_ready),   32'd0);
    chk("rst_rd_data",    32'(rd_data),    32'd0);
    chk("rst_rd_valid",   32'(rd_valid),   32'd0);
    chk("rst_rd_err",     32'(rd_err),     32'd0);
    chk("rst_front_bank", 32'(front_bank), 32'd0);
    chk("rst_swapped",    32'(swapped),    32'd0);
    rst_n = 1'b1;
    tick();
    chk("wr_ready_after_reset", 32'(wr_ready), 32'd1);

    // Frame 1 into bank 1, data = addr[8:0]
    for (int i = 0; i < int'(DEPTH); i++) begin
      write_px(i == 0, pat(0, i));
      if (i == 99) chk("f1_wr_count_100", 32'(wr_count), 32'd100);
    end
    chk("f1_full_wr_ready", 32'(wr_ready), 32'd0);
    chk("f1_full_wr_count", 32'(wr_count), 32'(DEPTH - 1));
    chk("f1_full_swapped",  32'(swapped),  32'd0);
    chk("f1_full_front",    32'(front_bank), 32'd0);
    tick();
    chk("f1_swap_pulse",    32'(swapped),  32'd1);
    chk("f1_swap_front",    32'(front_bank), 32'd1);
    chk("f1_swap_wr_ready", 32'(wr_ready), 32'd1);
    chk("f1_swap_wr_count", 32'(wr_count), 32'd0);
    ref_front = 1'b1; ref_wr_addr = 0;
    tick();
    chk("f1_swap_pulse_end", 32'(swapped), 32'd0);

    // Table-driven reads of frame 1, including out-of-range addresses
    for (int k = 0; k < 6; k++) issue_read(tbl[k].addr, tbl[k].exp_data, tbl[k].exp_err);
    issue_read(14'd255, 9'h0FF, 1'b0);
    tick();
    chk("rd_data_hold",  32'(rd_data),  32'h0FF);
    chk("rd_valid_idle", 32'(rd_valid), 32'd0);
    for (int k = 0; k < 12; k++) begin
      ra = int'($urandom_range(DEPTH - 1, 0));
      issue_read(ADDR_W'(ra), ref_mem[ref_front][ra], 1'b0);
    end

    // Frame 2 into bank 0 with the reader locking the front bank
    rd_lock = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) write_px(i == 0, pat(1, i));
    chk("f2_full_wr_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1; wr_sof = 1'b1; wr_data = 9'h155;
    for (int k = 0; k < 10; k++) begin
      if (k == 9) begin
        wr_valid = 1'b0; wr_sof = 1'b0;
      end
      tick();
      chk("lock_no_swap",  32'(swapped),    32'd0);
      chk("lock_wr_ready", 32'(wr_ready),   32'd0);
      chk("lock_front",    32'(front_bank), 32'd1);
      chk("lock_wr_count", 32'(wr_count),   32'(DEPTH - 1));
    end
    // Release the lock with a read on the swap edge: old front data comes back
    rd_lock = 1'b0;
    rd_en   = 1'b1;
    rd_addr = 14'd7;
    exp_q.push_back(rd_exp_t'{err: 1'b0, data: ref_mem[1][7]});
    tick();
    rd_en = 1'b0;
    chk("unlock_swap_pulse", 32'(swapped),    32'd1);
    chk("unlock_front",      32'(front_bank), 32'd0);
    ref_front = 1'b0; ref_wr_addr = 0;
    issue_read(14'd7, ref_mem[0][7], 1'b0);
    issue_read(14'd0, pat(1, 0), 1'b0);

    // Partial frame, then sof restart; a full frame is still needed to swap
    for (int i = 0; i < 100; i++) write_px(i == 0, pat(2, i));
    chk("sof_pre_wr_count", 32'(wr_count), 32'd100);
    write_px(1'b1, 9'h1AA);
    chk("sof_wr_count", 32'(wr_count), 32'd1);
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (i == int'(DEPTH) - 1) begin
        chk("sof_no_early_swap_front", 32'(front_bank), 32'd0);
        chk("sof_no_early_swap_ready", 32'(wr_ready),   32'd1);
      end
      write_px(1'b0, pat(3, i));
    end
    chk("sof_full_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    chk("sof_swap_pulse", 32'(swapped),    32'd1);
    chk("sof_swap_front", 32'(front_bank), 32'd1);
    ref_front = 1'b1; ref_wr_addr = 0;
    issue_read(14'd0, 9'h1AA, 1'b0);
    issue_read(14'd50, ref_mem[1][50], 1'b0);
    issue_read(14'd4799, ref_mem[1][4799], 1'b0);
    issue_read(14'd4800, 9'h000, 1'b1);

    // Reset in the middle of a frame into bank 0
    for (int i = 0; i < 2000; i++) write_px(i == 0, pat(4, i));
    chk("mid_wr_count", 32'(wr_count), 32'd2000);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_count", 32'(wr_count),   32'd0);
    chk("mid_rst_front",    32'(front_bank), 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready),   32'd0);
    chk("mid_rst_rd_data",  32'(rd_data),    32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid),   32'd0);
    chk("mid_rst_swapped",  32'(swapped),    32'd0);
    ref_front = 1'b0; ref_wr_addr = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_release_ready", 32'(wr_ready), 32'd1);
    // Bank 0 survives reset: partial frame below 2000, frame 2 above
    issue_read(14'd1999, pat(4, 1999), 1'b0);
    issue_read(14'd3000, pat(1, 3000), 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) write_px(1'b0, pat(5, i));
    tick();
    chk("post_rst_swap_pulse", 32'(swapped),    32'd1);
    chk("post_rst_swap_front", 32'(front_bank), 32'd1);
    ref_front = 1'b1; ref_wr_addr = 0;
    issue_read(14'd0, pat(5, 0), 1'b0);
    issue_read(14'd2500, ref_mem[1][2500], 1'b0);

    repeat (3) tick();
    chk("rd_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
